// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART controller: register map, STATUS/CTRL bit
// positions and TX sequencer states. CTRL loopback exists only with UART_CTRL_LOOPBACK_EN.
package uart_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_TX_NOT_FULL = 0;
  localparam int ST_RX_AVAIL    = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_OVERFLOW = 4;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_LOOPBACK  = 2;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push on a full FIFO still lands
// when a pop happens in the same cycle.
module uart_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Bus-mapped UART controller: TX FIFO + start/busy sequencer, RX capture FIFO,
// sticky error flags and a level IRQ. Define UART_CTRL_LOOPBACK_EN for CTRL loopback.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  output logic        irq_o
);

  tx_state_t   state;
  logic [2:0]  ctrl;
  logic        rx_ovr, tx_ovf;
  logic        req, rd, wr;
  logic [1:0]  sel;
  logic        data_wr, data_rd, st_wr, ctrl_wr;
  logic        tx_pop, tx_full, tx_empty, tx_idle;
  logic [7:0]  tx_head;
  logic        rx_push, rx_full, rx_empty;
  logic [7:0]  rx_din, rx_head;
  logic        lb_on;
  logic [4:0]  status;
  logic        unused_bits;

  assign unused_bits = ^{wb_dat_i[31:8], wb_adr_i[1:0]};

  // ack itself masks the request, so a held strobe is serviced every other cycle
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign sel     = wb_adr_i[3:2];
  assign rd      = req & ~wb_we_i;
  assign wr      = req &  wb_we_i;
  assign data_wr = wr & (sel == REG_DATA);
  assign data_rd = rd & (sel == REG_DATA);
  assign st_wr   = wr & (sel == REG_STATUS);
  assign ctrl_wr = wr & (sel == REG_CTRL);

  assign tx_pop  = (state == TX_START);
  assign tx_idle = tx_empty && (state == TX_IDLE);

`ifdef UART_CTRL_LOOPBACK_EN
  assign lb_on   = ctrl[CTRL_LOOPBACK];
  assign rx_push = lb_on ? tx_pop : rx_ready_i;
  assign rx_din  = lb_on ? tx_data_o : rx_data_i;
`else
  assign lb_on   = 1'b0;
  assign rx_push = rx_ready_i;
  assign rx_din  = rx_data_i;
`endif

  uart_ctrl_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) tx_fifo (
    .clk(clk), .rst(rst), .push(data_wr), .pop(tx_pop), .din(wb_dat_i[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_ctrl_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(data_rd), .din(rx_din),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    status = '0;
    status[ST_TX_NOT_FULL] = ~tx_full;
    status[ST_RX_AVAIL]    = ~rx_empty;
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_RX_OVERRUN]  = rx_ovr;
    status[ST_TX_OVERFLOW] = tx_ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctrl     <= '0;
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= '0;
      if (rd) begin
        case (sel)
          REG_DATA:   wb_dat_o <= rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
          REG_STATUS: wb_dat_o <= {27'd0, status};
          REG_CTRL:   wb_dat_o <= {29'd0, ctrl};
          default:    wb_dat_o <= '0;
        endcase
      end
      if (ctrl_wr) begin
        ctrl[CTRL_RX_IRQ_EN] <= wb_dat_i[CTRL_RX_IRQ_EN];
        ctrl[CTRL_TX_IRQ_EN] <= wb_dat_i[CTRL_TX_IRQ_EN];
`ifdef UART_CTRL_LOOPBACK_EN
        ctrl[CTRL_LOOPBACK]  <= wb_dat_i[CTRL_LOOPBACK];
`endif
      end
      // a set event wins over a same-cycle write-1-to-clear
      rx_ovr <= (rx_ovr & ~(st_wr & wb_dat_i[ST_RX_OVERRUN]))
              | (rx_push & rx_full & ~data_rd);
      tx_ovf <= (tx_ovf & ~(st_wr & wb_dat_i[ST_TX_OVERFLOW]))
              | (data_wr & tx_full & ~tx_pop);
      irq_o  <= (ctrl[CTRL_RX_IRQ_EN] & (~rx_empty | rx_ovr))
              | (ctrl[CTRL_TX_IRQ_EN] & tx_idle);
    end
  end

  // head byte is latched on entry to START, so the pop in START is safe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= TX_IDLE;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!tx_empty && !tx_busy_i) begin
            state      <= TX_START;
            tx_start_o <= ~lb_on;
            tx_data_o  <= tx_head;
          end
        end
        TX_START: begin
          tx_start_o <= 1'b0;
          state      <= lb_on ? TX_IDLE : TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: if (tx_busy_i)  state <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!tx_busy_i) state <= TX_IDLE;
        default: begin
          state      <= TX_IDLE;
          tx_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: directed scenarios plus randomized bus/RX
// traffic checked against a queue-based model of the register map.
module tb_uart_ctrl;

  localparam int TXD = 16;
  localparam int RXD = 16;
  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i = 1'b0;
  logic        rx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        irq_o;

  always #5 clk = ~clk;

  uart_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i),
    .rx_ready_i(rx_ready_i), .rx_data_i(rx_data_i), .irq_o(irq_o)
  );

  typedef struct {
    bit          en;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] lbq[$];
  bit         ovr = 0, ovf = 0;
  logic [2:0] ctrl_m = '0;
  int         checks = 0, failures = 0;
  int         tx_phase = 0;
  bit         busy_hold = 0;
  bit         prev_ack = 0, prev_start = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input int val);
    checks++;
    failures++;
    $display("FAIL %s value=%0d", name, val);
  endtask

  function automatic logic [31:0] status_m();
    return {27'd0, ovf, ovr, (txq.size() == 0 && tx_phase == 0),
            (rxq.size() != 0), (txq.size() < TXD)};
  endfunction

  task automatic rx_push_m(input logic [7:0] b);
    if (rxq.size() < RXD) rxq.push_back(b);
    else ovr = 1;
  endtask

  // transmitter model: busy rises in the start cycle and stays up 2..6 cycles
  initial begin
    forever begin
      @(posedge clk); #2;
      if (busy_hold) tx_busy_i = 1'b1;
      else if (tx_start_o) begin
        tx_busy_i = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #2 tx_busy_i = 1'b0;
      end else tx_busy_i = 1'b0;
    end
  end

  // bus monitor
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (wb_ack_o) begin
        chk("ack_width", {31'd0, prev_ack}, 32'd0);
        if (sb.size() == 0) fail("ack_unexpected", 0);
        else begin
          e = sb.pop_front();
          if (e.en) chk("rd_data", wb_dat_o & e.mask, e.exp & e.mask);
        end
      end
      prev_ack = wb_ack_o;
    end
  end

  // transmitter-side monitor
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start_o) begin
        chk("start_width", {31'd0, prev_start}, 32'd0);
        chk("tx_handshake", tx_phase, 0);
        if (txq.size() == 0) fail("tx_unexpected", int'(tx_data_o));
        else chk("tx_data", {24'd0, tx_data_o}, {24'd0, txq.pop_front()});
        tx_phase = 1;
      end else if (tx_phase == 1 && tx_busy_i) tx_phase = 2;
      else if (tx_phase == 2 && !tx_busy_i) tx_phase = 0;
      prev_start = tx_start_o;
    end
  end

  task automatic do_op(input bit we, input logic [1:0] r, input logic [31:0] d,
                       input bit p, input logic [7:0] b, input logic [31:0] m);
    sb_t e;
    e.en = !we; e.mask = m; e.exp = '0;
    case (r)
      2'd0: begin
        if (we) begin
          if (ctrl_m[2]) lbq.push_back(d[7:0]);
          else if (txq.size() < TXD) txq.push_back(d[7:0]);
          else ovf = 1;
        end else if (rxq.size() != 0) e.exp = {23'd0, 1'b1, rxq.pop_front()};
      end
      2'd1: begin
        if (we) begin
          if (d[3]) ovr = 0;
          if (d[4]) ovf = 0;
        end else e.exp = status_m();
      end
      2'd2: begin
`ifdef UART_CTRL_LOOPBACK_EN
        if (we) ctrl_m = d[2:0];
`else
        if (we) ctrl_m = {1'b0, d[1:0]};
`endif
        else e.exp = {29'd0, ctrl_m};
      end
      default: ;
    endcase
    if (p && !ctrl_m[2]) rx_push_m(b);
    sb.push_back(e);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = {r, 2'b00}; wb_dat_i = d;
    rx_ready_i = p; rx_data_i = b;
    @(posedge clk); #1;
    chk("ack_rise", {31'd0, wb_ack_o}, 32'd1);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; rx_ready_i = 0;
    @(posedge clk); #1;
    chk("ack_fall", {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_ready_i = 1; rx_data_i = b;
    if (!ctrl_m[2]) rx_push_m(b);
    @(posedge clk); #1;
    rx_ready_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((txq.size() != 0 || tx_phase != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 3000) fail("tx_drain_timeout", txq.size());
    idle(3);
  endtask

  task automatic do_reset();
    rst = 0;
    idle(3);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_start", {31'd0, tx_start_o}, 32'd0);
    chk("rst_txdata", {24'd0, tx_data_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    txq.delete(); rxq.delete(); lbq.delete();
    ovr = 0; ovf = 0; ctrl_m = '0;
    rst = 1;
    idle(1);
  endtask

  initial begin
    #900000;
    fail("global_timeout", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit p;
    logic [7:0] b;
    logic [31:0] d;

    do_reset();
    do_op(0, 2'd1, 0, 0, 0, FULL);

    // two bytes sequenced through the start/busy handshake
    do_op(1, 2'd0, 32'h41, 0, 0, 0);
    do_op(1, 2'd0, 32'h42, 0, 0, 0);
    wait_quiet();
    do_op(0, 2'd1, 0, 0, 0, FULL);

    // TX overflow with the transmitter held busy
    busy_hold = 1;
    idle(3);
    for (int i = 0; i < 17; i++) do_op(1, 2'd0, 32'h60 + i, 0, 0, 0);
    do_op(0, 2'd1, 0, 0, 0, FULL);
    do_op(1, 2'd1, 32'h10, 0, 0, 0);
    do_op(0, 2'd1, 0, 0, 0, FULL);
    busy_hold = 0;
    wait_quiet();
    do_op(0, 2'd1, 0, 0, 0, FULL);

    // single RX byte, then read on empty
    rx_pulse(8'h5A);
    do_op(0, 2'd0, 0, 0, 0, FULL);
    do_op(0, 2'd0, 0, 0, 0, FULL);

    // RX overrun and ordering
    for (int i = 0; i < 17; i++) rx_pulse(8'($urandom));
    do_op(0, 2'd1, 0, 0, 0, FULL);
    do_op(1, 2'd1, 32'h08, 0, 0, 0);
    for (int i = 0; i < 16; i++) do_op(0, 2'd0, 0, 0, 0, FULL);
    for (int i = 0; i < 16; i++) rx_pulse(8'($urandom));
    do_op(0, 2'd0, 0, 1, 8'hC3, FULL);
    do_op(0, 2'd1, 0, 0, 0, FULL);
    for (int i = 0; i < 17; i++) do_op(0, 2'd0, 0, 0, 0, FULL);

    // interrupt timing
    do_op(1, 2'd2, 32'h1, 0, 0, 0);
    rx_pulse(8'h33);
    chk("irq_lag", {31'd0, irq_o}, 32'd0);
    idle(1);
    chk("irq_set", {31'd0, irq_o}, 32'd1);
    do_op(0, 2'd0, 0, 0, 0, FULL);
    chk("irq_clr", {31'd0, irq_o}, 32'd0);
    do_op(1, 2'd2, 32'h2, 0, 0, 0);
    idle(1);
    chk("irq_txidle", {31'd0, irq_o}, 32'd1);
    do_op(1, 2'd2, 32'h0, 0, 0, 0);
    chk("irq_off", {31'd0, irq_o}, 32'd0);

`ifdef UART_CTRL_LOOPBACK_EN
    do_op(1, 2'd2, 32'h4, 0, 0, 0);
    do_op(1, 2'd0, 32'h7E, 0, 0, 0);
    idle(6);
    while (lbq.size() != 0) rx_push_m(lbq.pop_front());
    do_op(0, 2'd0, 0, 0, 0, FULL);
    do_op(1, 2'd2, 32'h0, 0, 0, 0);
`else
    do_op(1, 2'd2, 32'h7, 0, 0, 0);
    do_op(0, 2'd2, 0, 0, 0, FULL);
    do_op(1, 2'd2, 32'h0, 0, 0, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      p = ($urandom_range(0, 9) < 5);
      b = 8'($urandom);
      d = $urandom;
      case (k)
        0, 1: begin
          if (txq.size() < TXD - 2) do_op(1, 2'd0, d, p, b, 0);
          else do_op(0, 2'd0, 0, p, b, FULL);
        end
        2, 3, 4: do_op(0, 2'd0, d, p, b, FULL);
        5: do_op(0, 2'd1, d, p, b, 32'h1B);
        6: do_op(1, 2'd1, d, p, b, 0);
        7: do_op(1, 2'd2, d & ~32'h4, p, b, 0);
        8: do_op(0, 2'd2, d, p, b, FULL);
        default: begin
          if ($urandom_range(0, 1) == 1) rx_pulse(b);
          else do_op(d[8], 2'd3, d, p, b, FULL);
        end
      endcase
    end

    // reset abandons buffered RX data
    rx_pulse(8'hAA);
    wait_quiet();
    do_reset();
    do_op(0, 2'd1, 0, 0, 0, FULL);
    do_op(0, 2'd0, 0, 0, 0, FULL);

    idle(4);
    if (sb.size() != 0) fail("sb_leftover", sb.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Register-mapped controller that sits between the CPU's Wishbone-style peripheral bus and the UART async transmitter/receiver pair. It buffers outgoing bytes in a TX FIFO and sequences the transmitter's start/busy handshake one byte at a time. It captures every receiver data-ready pulse into an RX FIFO, and exposes data, status and control registers plus one level interrupt.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 2
RX_DEPTH, 16, RX FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-low
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  4  byte address; bits [3:2] select the register
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, valid while wb_ack_o is high
wb_ack_o  out  1  single-cycle acknowledge
tx_start_o  out  1  start pulse to transmitter
tx_data_o  out  8  byte to transmitter, stable while tx_start_o is high
tx_busy_i  in  1  transmitter busy
rx_ready_i  in  1  receiver one-cycle data-ready pulse
rx_data_i  in  8  receiver byte, valid with rx_ready_i
irq_o  out  1  registered interrupt, level

Behaviour:
- Reset (rst==0 at a clk edge): both FIFOs empty; TX FSM goes to IDLE; CTRL=0; sticky flags=0. Outputs: wb_ack_o=0, wb_dat_o=0, tx_start_o=0, tx_data_o=0, irq_o=0. Reset mid-transfer abandons the queued bytes. A byte already started in the transmitter is not tracked.
- Registers, selected by adr[3:2]:
  - 0 DATA. Write pushes wb_dat_i[7:0] to the TX FIFO. Read pops the RX FIFO and returns {23'b0, valid, byte}.
  - 1 STATUS. Read returns bit0 tx_not_full, bit1 rx_avail, bit2 tx_idle (FIFO empty and FSM IDLE), bit3 rx_overrun, bit4 tx_overflow. Write: bits 3 and 4 are write-1-to-clear.
  - 2 CTRL, R/W. bit0 rx_irq_en, bit1 tx_irq_en, bit2 loopback (only when the optional feature is compiled in, otherwise reads 0).
  - 3 reserved. Reads 0, writes ignored.
- Bus handshake:
  - wb_ack_o rises 1 cycle after cyc&stb&~ack and is high for exactly 1 cycle.
  - The access side-effect (push/pop/clear) happens on the same edge that raises ack.
  - A held strobe gives one ack every 2 cycles.
- DATA write with TX FIFO full: byte dropped, tx_overflow set. DATA read with RX empty: returns 0, no pop.
- TX FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE → START when the FIFO is non-empty and tx_busy_i==0.
  - START: tx_start_o=1 for 1 cycle, tx_data_o=FIFO head, pop. Then go to WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when tx_busy_i==1.
  - WAIT_DONE → IDLE when tx_busy_i==0.
  - Minimum per-byte overhead is 2 cycles beyond the transmitter's busy time.
- RX capture:
  - rx_ready_i pushes rx_data_i into the RX FIFO.
  - Push on full with no same-cycle pop: byte dropped, rx_overrun set.
  - Push and pop in the same cycle on a full FIFO: both succeed, count unchanged.
- Sticky-flag priority: a set event and a W1C clear in the same cycle leaves the flag set.
- irq_o is registered, 1 cycle after its terms change: (rx_irq_en & (rx_avail|rx_overrun)) | (tx_irq_en & tx_idle).
- FIFO pointers are log2(DEPTH)+1 bits. The MSB is the wrap bit. Full means the indices are equal and the wrap bits differ.

Optional Feature:
UART_CTRL_LOOPBACK_EN.
- Defined: CTRL bit2 is implemented. While it is set:
  - START pushes the TX head directly into the RX FIFO (with overrun rules), then returns to IDLE.
  - tx_start_o stays 0.
  - rx_ready_i is ignored.
- Undefined: bit2 reads 0 and no loopback logic is synthesized.

Decomposition:
- Package uart_ctrl_pkg contains:
  - register index constants (DATA=0, STATUS=1, CTRL=2)
  - STATUS and CTRL bit positions
  - TX FSM state encoding (2 bits)
- Sub-module uart_ctrl_fifo: synchronous FIFO parameterized by width and depth, with push, pop, head, full, empty, same-cycle push+pop on full. Instantiated twice.

Test Plan:
- Reset, then write DATA 0x41, 0x42 → tx_start_o pulses with tx_data_o=0x41, then 0x42 only after tx_busy_i has risen and fallen. STATUS bit2=1 at the end.
- Write 17 bytes with TX_DEPTH=16 and tx_busy_i held high → 16 queued, STATUS=0x10; writing STATUS 0x10 then clears bit4.
- Pulse rx_ready_i with 0x5A, then read DATA → wb_dat_o=0x15A. A second read returns 0x000.
- Send 17 rx_ready_i pulses with no reads → rx_overrun=1 and the first 16 bytes read back in order. Also drive a push and a pop in the same cycle on a full RX FIFO → no overrun.
- CTRL=0x1, rx_ready_i 0x33 → irq_o=1 two cycles after the pulse; irq_o=0 two cycles after the DATA read ack.
- With UART_CTRL_LOOPBACK_EN: CTRL=0x4, write DATA 0x7E → tx_start_o never pulses; a DATA read returns 0x17E.
